// File: rtl/dms_dlf.sv
// dms_dlf: proportional-integral loop filter turning a signed phase error into a saturated DCO control word.
// Defining DMS_DLF_POLE_EN adds a third stage: a first-order smoothing pole on the control word.
module dms_dlf #(
    parameter int unsigned IN_W       = 4,
    parameter int unsigned INT_W      = 24,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned KP_SHIFT   = 4,
    parameter int unsigned KI_SHIFT   = 8,
    parameter int          INIT_CTRL  = 0,
    parameter int unsigned POLE_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    freeze,
    input  logic                    err_valid,
    input  logic signed [IN_W-1:0]  err,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] ctrl,
    output logic                    int_sat
);

    localparam int unsigned ACC_W = INT_W + 1;
    localparam int unsigned ISH_W = INT_W - KI_SHIFT;
    localparam int unsigned P_W   = IN_W + KP_SHIFT;
    localparam int unsigned SUM_W = ((ISH_W > P_W) ? ISH_W : P_W) + 1;
    localparam int unsigned SAT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    localparam longint INT_MAX_L = (longint'(1) <<< (INT_W - 1)) - longint'(1);
    localparam longint INT_MIN_L = -(longint'(1) <<< (INT_W - 1));
    localparam longint OUT_MAX_L = (longint'(1) <<< (OUT_W - 1)) - longint'(1);
    localparam longint OUT_MIN_L = -(longint'(1) <<< (OUT_W - 1));

    localparam longint INIT_INT_RAW = longint'(INIT_CTRL) <<< KI_SHIFT;
    localparam longint INIT_INT_L   = (INIT_INT_RAW > INT_MAX_L) ? INT_MAX_L :
                                      (INIT_INT_RAW < INT_MIN_L) ? INT_MIN_L : INIT_INT_RAW;
    localparam longint INIT_OUT_L   = (longint'(INIT_CTRL) > OUT_MAX_L) ? OUT_MAX_L :
                                      (longint'(INIT_CTRL) < OUT_MIN_L) ? OUT_MIN_L :
                                      longint'(INIT_CTRL);

    localparam logic signed [INT_W-1:0] INT_MAX   = INT_W'(INT_MAX_L);
    localparam logic signed [INT_W-1:0] INT_MIN   = INT_W'(INT_MIN_L);
    localparam logic signed [INT_W-1:0] INIT_INT  = INT_W'(INIT_INT_L);
    localparam logic signed [OUT_W-1:0] INIT_OUT  = OUT_W'(INIT_OUT_L);
    localparam logic                    INIT_SAT  = (INIT_INT_L == INT_MAX_L) || (INIT_INT_L == INT_MIN_L);
    localparam logic signed [SAT_W-1:0] OUT_MAX_S = SAT_W'(OUT_MAX_L);
    localparam logic signed [SAT_W-1:0] OUT_MIN_S = SAT_W'(OUT_MIN_L);

    // Elaboration guard against parameter sets the datapath widths cannot support
    if (POLE_SHIFT > OUT_W || IN_W > INT_W || KI_SHIFT >= INT_W) begin : g_param_check
        $error("dms_dlf: unsupported parameter combination");
    end

    logic signed [INT_W-1:0] integ;
    logic signed [INT_W-1:0] integ_nxt;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [IN_W-1:0]  err_q;
    logic                    v1;

    // Stage 1 accumulator with clamp instead of wrap
    always_comb begin
        acc_sum   = ACC_W'(integ) + ACC_W'(err);
        integ_nxt = INT_W'(acc_sum);
        if (acc_sum[ACC_W-1] != acc_sum[ACC_W-2]) begin
            integ_nxt = acc_sum[ACC_W-1] ? INT_MIN : INT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ   <= INIT_INT;
            err_q   <= '0;
            v1      <= 1'b0;
            int_sat <= INIT_SAT;
        end else if (clr) begin
            integ   <= INIT_INT;
            err_q   <= '0;
            v1      <= 1'b0;
            int_sat <= INIT_SAT;
        end else begin
            v1 <= err_valid;
            if (err_valid) begin
                err_q <= err;
                if (!freeze) begin
                    integ   <= integ_nxt;
                    int_sat <= (integ_nxt == INT_MAX) || (integ_nxt == INT_MIN);
                end
            end
        end
    end

    logic signed [SUM_W-1:0] i_term;
    logic signed [SUM_W-1:0] p_term;
    logic signed [SAT_W-1:0] pi_wide;
    logic signed [OUT_W-1:0] pi_sat;

    // Stage 2 PI sum; SUM_W leaves one bit of headroom so only the output clamp can limit
    always_comb begin
        i_term  = SUM_W'(integ >>> KI_SHIFT);
        p_term  = SUM_W'(err_q) <<< KP_SHIFT;
        pi_wide = SAT_W'(i_term + p_term);
        pi_sat  = OUT_W'(pi_wide);
        if (pi_wide > OUT_MAX_S) begin
            pi_sat = OUT_W'(OUT_MAX_L);
        end else if (pi_wide < OUT_MIN_S) begin
            pi_sat = OUT_W'(OUT_MIN_L);
        end
    end

`ifdef DMS_DLF_POLE_EN
    localparam int unsigned PD_W = OUT_W + 2;
    localparam logic signed [PD_W-1:0] OUT_MAX_P = PD_W'(OUT_MAX_L);
    localparam logic signed [PD_W-1:0] OUT_MIN_P = PD_W'(OUT_MIN_L);

    logic signed [OUT_W-1:0] x_q;
    logic                    v2;
    logic signed [PD_W-1:0]  pole_step;
    logic signed [PD_W-1:0]  pole_sum;
    logic signed [OUT_W-1:0] y_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= INIT_OUT;
            v2  <= 1'b0;
        end else if (clr) begin
            x_q <= INIT_OUT;
            v2  <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                x_q <= pi_sat;
            end
        end
    end

    // Stage 3 pole: y moves 2^-POLE_SHIFT of the way toward the PI result
    always_comb begin
        pole_step = (PD_W'(x_q) - PD_W'(ctrl)) >>> POLE_SHIFT;
        pole_sum  = PD_W'(ctrl) + pole_step;
        y_nxt     = OUT_W'(pole_sum);
        if (pole_sum > OUT_MAX_P) begin
            y_nxt = OUT_W'(OUT_MAX_L);
        end else if (pole_sum < OUT_MIN_P) begin
            y_nxt = OUT_W'(OUT_MIN_L);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= INIT_OUT;
            out_valid <= 1'b0;
        end else if (clr) begin
            ctrl      <= INIT_OUT;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                ctrl <= y_nxt;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= INIT_OUT;
            out_valid <= 1'b0;
        end else if (clr) begin
            ctrl      <= INIT_OUT;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                ctrl <= pi_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dms_dlf.sv
// Directed bench for dms_dlf: vector table plus hand sequences for ramp, freeze, clear, reset and saturation.
module tb_dms_dlf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, clr, freeze, err_valid;
    logic signed [3:0]  err;
    logic               out_valid, int_sat;
    logic signed [15:0] ctrl;

    logic               s_clr, s_freeze, s_valid;
    logic signed [3:0]  s_err;
    logic               s_ov, s_sat;
    logic signed [15:0] s_ctrl;

    dms_dlf u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .freeze(freeze), .err_valid(err_valid),
        .err(err), .out_valid(out_valid), .ctrl(ctrl), .int_sat(int_sat)
    );

    dms_dlf #(.INT_W(12)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .freeze(s_freeze), .err_valid(s_valid),
        .err(s_err), .out_valid(s_ov), .ctrl(s_ctrl), .int_sat(s_sat)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic c;
        logic f;
        logic v;
        int   e;
        logic ov;
        int   ctrl;
        logic sat;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one active edge pass, return at the next negedge
    task automatic cyc(input logic c, input logic f, input logic v, input int e);
        clr = c; freeze = f; err_valid = v; err = 4'(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc_s(input logic v, input int e);
        s_valid = v; s_err = 4'(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; freeze = 1'b0; err_valid = 1'b0; err = '0;
        s_clr = 1'b0; s_freeze = 1'b0; s_valid = 1'b0; s_err = '0;

        repeat (2) @(negedge clk);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_sat", int_sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef DMS_DLF_POLE_EN
        cyc(0, 0, 1, 1); chk("pole_ov_c1", out_valid, 0);
        cyc(0, 0, 1, 1); chk("pole_ov_c2", out_valid, 0);
        cyc(0, 0, 1, 1); chk("pole_ov_c3", out_valid, 1); chk("pole_ctrl_c3", ctrl, 2);
        cyc(0, 0, 1, 1); chk("pole_ov_c4", out_valid, 1); chk("pole_ctrl_c4", ctrl, 3);
        cyc(0, 0, 0, 0); chk("pole_ov_c5", out_valid, 1); chk("pole_ctrl_c5", ctrl, 4);
        cyc(0, 0, 0, 0); chk("pole_ov_c6", out_valid, 1); chk("pole_ctrl_c6", ctrl, 5);
        cyc(0, 0, 0, 0); chk("pole_ov_c7", out_valid, 0); chk("pole_hold_c7", ctrl, 5);
        cyc(1, 0, 1, 3); chk("pole_clr_ov", out_valid, 0); chk("pole_clr_ctrl", ctrl, 0);
        cyc(0, 0, 0, 0); chk("pole_clr_ov2", out_valid, 0);
        cyc(0, 0, 0, 0); chk("pole_clr_ov3", out_valid, 0);
`else
        // {clr, freeze, valid, err, exp out_valid, exp ctrl, exp int_sat} after each edge
        tbl[0]  = '{1'b0, 1'b0, 1'b1,  1, 1'b0,    0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1,  1, 1'b1,   16, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0,  0, 1'b1,   16, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0,   16, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, -8, 1'b0,   16, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1,  7, 1'b1, -129, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0,  0, 1'b1,  111, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0,  111, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1,  6, 1'b0,  111, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0,  0, 1'b1,   96, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1,  5, 1'b0,    0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0,  0, 1'b0,    0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0,  0, 1'b0,    0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].c, tbl[i].f, tbl[i].v, tbl[i].e);
            chk($sformatf("vec%0d_ov", i), out_valid, tbl[i].ov);
            chk($sformatf("vec%0d_ctrl", i), ctrl, tbl[i].ctrl);
            chk($sformatf("vec%0d_sat", i), int_sat, tbl[i].sat);
        end

        // 256-sample ramp of +1
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 1, 1);
            if (i == 0) begin
                chk("ramp_first_ov", out_valid, 0);
            end else begin
                chk("ramp_ov", out_valid, 1);
                chk("ramp_ctrl", ctrl, 16);
            end
        end
        cyc(0, 0, 0, 0);
        chk("ramp_last_ov", out_valid, 1);
        chk("ramp_last_ctrl", ctrl, 17);
        chk("ramp_sat", int_sat, 0);

        // Freeze at integ=256 with err=-3
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, -3);
            if (i == 0) begin
                chk("frz_first_ov", out_valid, 0);
            end else begin
                chk("frz_ov", out_valid, 1);
                chk("frz_ctrl", ctrl, -47);
            end
        end
        cyc(0, 0, 1, 0);
        chk("frz_last_ctrl", ctrl, -47);
        cyc(0, 0, 0, 0);
        chk("unfrz_ov", out_valid, 1);
        chk("unfrz_ctrl", ctrl, 1);

        // Clear, pump integ to 1000, then clr colliding with a sample
        cyc(1, 0, 0, 0);
        chk("clr0_ctrl", ctrl, 0);
        for (int i = 0; i < 142; i++) cyc(0, 0, 1, 7);
        cyc(0, 0, 1, 6);
        chk("pump_ctrl", ctrl, 115);
        cyc(1, 0, 1, 5);
        chk("clr_ov", out_valid, 0);
        chk("clr_ctrl", ctrl, 0);
        chk("clr_sat", int_sat, 0);
        cyc(0, 0, 0, 0);
        chk("clr_ov_next", out_valid, 0);
        chk("clr_ctrl_next", ctrl, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("clr_integ_ov", out_valid, 1);
        chk("clr_integ_ctrl", ctrl, 0);

        // Async reset mid-pipeline
        cyc(0, 0, 1, 3);
        cyc(0, 0, 1, 3);
        chk("pre_rst_ctrl", ctrl, 48);
        chk("pre_rst_ov", out_valid, 1);
        err_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", ctrl, 0);
        chk("async_rst_ov", out_valid, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("post_rst_ov", out_valid, 0);
        end
        chk("post_rst_ctrl", ctrl, 0);

        // Integrator saturation on the INT_W=12 instance
        for (int i = 0; i < 400; i++) cyc_s(1, 7);
        chk("sat_flag", s_sat, 1);
        chk("sat_ov", s_ov, 1);
        cyc_s(1, -8);
        chk("sat_ctrl", s_ctrl, 119);
        chk("sat_release_flag", s_sat, 0);
        cyc_s(0, 0);
        chk("sat_release_ov", s_ov, 1);
        chk("sat_release_ctrl", s_ctrl, -121);
        cyc_s(0, 0);
        chk("sat_idle_ov", s_ov, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
